// File: rtl/ddr3_axi_pkg.sv
// Shared definitions for the DDR3 stream writer.
//   AXI write-response codes, writer FSM state encoding and the fixed
//   descriptor field widths (the length field width follows AXI_BURST_WIDTH).
package ddr3_axi_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
   localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_AW   = 2'd1,
      WR_W    = 2'd2,
      WR_B    = 2'd3
   } wr_state_e;

   localparam int DESC_END_W   = 1;
   localparam int DESC_BYTES_W = 16;

endpackage

// File: rtl/ddr3_stream_writer_sfifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk_sys/rst_b : clock, active-low async reset (empties the FIFO)
//   wr_en/wr_data : push, ignored while fifo_full
//   rd_en/rd_data : pop; rd_data shows the head entry whenever !fifo_empty
//   fifo_full/fifo_empty : status
// DEPTH must be a power of 2.
module sfifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             fifo_full,
   output logic             fifo_empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic             wr_ok, rd_ok;

   // Extra pointer bit separates full from empty when the indices match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign rd_data    = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      wr_ok    = wr_en & ~fifo_full;
      rd_ok    = rd_en & ~fifo_empty;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(wr_ok);
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(rd_ok);
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (wr_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
   end

endmodule

// File: rtl/ddr3_stream_writer.sv
// Byte stream to DDR3 AXI write-burst master.
//   aclk/aresetn            : clock, active-low async reset
//   s_data/s_valid/s_last   : incoming frame bytes; s_ready back-pressure
//   aw*/w*/b*               : AXI write master towards the DDR3 controller
//   frame_done/frame_bytes  : one-cycle pulse with the byte count of a frame
//                             whose last burst has been acknowledged
//   wr_err                  : sticky, set on any non-OKAY write response
// Bytes are packed little-endian into words; every BURST_BEATS words (or at
// frame end) a descriptor goes to a small FIFO, which the writer FSM turns
// into one AW + W burst + B. Frames start on burst boundaries of a ring.
//
// Writer FSM
//   state   | meaning
//   WR_IDLE | waiting for a descriptor; pops and latches it
//   WR_AW   | presenting the burst address until awready
//   WR_W    | streaming len beats from the data FIFO
//   WR_B    | waiting for the write response; may pulse frame_done
module ddr3_stream_writer
   import ddr3_axi_pkg::*;
#(
   parameter int                        AXI_ADDR_WIDTH  = 32,
   parameter int                        AXI_ID_WIDTH    = 4,
   parameter int                        AXI_BURST_WIDTH = 6,
   parameter int                        AXI_DATA_WIDTH  = 128,
   parameter int                        BURST_BEATS     = 16,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
   parameter int                        REGION_BEATS    = 4096,
   parameter logic [AXI_ID_WIDTH-1:0]   WR_ID           = '0
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [7:0]                   s_data,
   input  logic                         s_valid,
   input  logic                         s_last,
   output logic                         s_ready,
   output logic [AXI_ADDR_WIDTH-1:0]    awaddr,
   output logic [AXI_ID_WIDTH-1:0]      awid,
   output logic [AXI_BURST_WIDTH-1:0]   awlen,
   output logic                         awvalid,
   input  logic                         awready,
   output logic [AXI_DATA_WIDTH-1:0]    wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]  wstrb,
   output logic                         wlast,
   output logic                         wvalid,
   input  logic                         wready,
   input  logic [AXI_ID_WIDTH-1:0]      bid,
   input  logic [1:0]                   bresp,
   input  logic                         bvalid,
   output logic                         bready,
   output logic                         frame_done,
   output logic [15:0]                  frame_bytes,
   output logic                         wr_err
);

   localparam int BPW           = AXI_DATA_WIDTH/8;
   localparam int BI_W          = $clog2(BPW);
   localparam int DF_W          = AXI_DATA_WIDTH + BPW;
   localparam int DESC_W        = AXI_BURST_WIDTH + DESC_END_W + DESC_BYTES_W;
   localparam int OFF_W         = $clog2(REGION_BEATS);
   localparam int COLS_PER_BEAT = AXI_DATA_WIDTH/16;

   // ---------------- packer ----------------
   logic [AXI_DATA_WIDTH-1:0]  pk_word_q, pk_word_d, merged_word;
   logic [BPW-1:0]             pk_strb_q, pk_strb_d, merged_strb;
   logic [BI_W-1:0]            pk_idx_q, pk_idx_d;
   logic [AXI_BURST_WIDTH-1:0] pk_words_q, pk_words_d;
   logic [15:0]                pk_bytes_q, pk_bytes_d;
   logic                       rdy_en_q;
   logic                       byte_acc, dfifo_wr, qfifo_wr;
   logic                       data_full, data_empty, desc_full, desc_empty;
   logic [DF_W-1:0]            data_rd;
   logic [DESC_W-1:0]          desc_rd, desc_wr;

   // ---------------- writer ----------------
   wr_state_e                  state_q, state_d;
   logic [AXI_BURST_WIDTH-1:0] len_m1_q, len_m1_d;
   logic [AXI_BURST_WIDTH-1:0] beats_left_q, beats_left_d;
   logic                       end_q, end_d;
   logic [15:0]                bytes_q, bytes_d;
   logic [OFF_W-1:0]           off_q, off_d;
   logic [OFF_W:0]             off_sum;
   logic                       err_q, err_d;
   logic                       done_q, done_d;
   logic [15:0]                done_bytes_q, done_bytes_d;
   logic                       desc_pop, data_pop;

   logic unused_bid;
   assign unused_bid = ^bid;

   // s_ready is held low for the first cycle out of reset.
   assign s_ready  = rdy_en_q & ~data_full & ~desc_full;
   assign byte_acc = s_valid & s_ready;

   always_comb begin
      pk_word_d   = pk_word_q;
      pk_strb_d   = pk_strb_q;
      pk_idx_d    = pk_idx_q;
      pk_words_d  = pk_words_q;
      pk_bytes_d  = pk_bytes_q;
      dfifo_wr    = 1'b0;
      qfifo_wr    = 1'b0;
      merged_word = pk_word_q;
      merged_word[{pk_idx_q, 3'b000} +: 8] = s_data;
      merged_strb = pk_strb_q;
      merged_strb[pk_idx_q] = 1'b1;
      if (byte_acc) begin
         pk_word_d  = merged_word;
         pk_strb_d  = merged_strb;
         pk_idx_d   = pk_idx_q + 1'b1;
         pk_bytes_d = pk_bytes_q + 16'd1;
         if ((pk_idx_q == BI_W'(BPW-1)) || s_last) begin
            dfifo_wr   = 1'b1;
            pk_word_d  = '0;
            pk_strb_d  = '0;
            pk_idx_d   = '0;
            pk_words_d = pk_words_q + 1'b1;
            // A frame ending on a full burst still yields a single descriptor.
            if ((pk_words_q == AXI_BURST_WIDTH'(BURST_BEATS-1)) || s_last) begin
               qfifo_wr   = 1'b1;
               pk_words_d = '0;
            end
            if (s_last) pk_bytes_d = '0;
         end
      end
   end

   // Descriptor: {len-1, frame_end, frame byte count including this byte}.
   assign desc_wr = {pk_words_q, s_last, pk_bytes_q + 16'd1};

   sfifo #(.WIDTH(DF_W), .DEPTH(32)) u_data_fifo (
      .clk_sys    (aclk),
      .rst_b      (aresetn),
      .wr_en      (dfifo_wr),
      .wr_data    ({merged_strb, merged_word}),
      .rd_en      (data_pop),
      .rd_data    (data_rd),
      .fifo_full  (data_full),
      .fifo_empty (data_empty)
   );

   sfifo #(.WIDTH(DESC_W), .DEPTH(4)) u_desc_fifo (
      .clk_sys    (aclk),
      .rst_b      (aresetn),
      .wr_en      (qfifo_wr),
      .wr_data    (desc_wr),
      .rd_en      (desc_pop),
      .rd_data    (desc_rd),
      .fifo_full  (desc_full),
      .fifo_empty (desc_empty)
   );

   // Words of a burst are already queued when its descriptor appears, so W
   // never looks at data_empty.
   always_comb begin
      state_d      = state_q;
      len_m1_d     = len_m1_q;
      beats_left_d = beats_left_q;
      end_d        = end_q;
      bytes_d      = bytes_q;
      off_d        = off_q;
      err_d        = err_q;
      done_d       = 1'b0;
      done_bytes_d = done_bytes_q;
      desc_pop     = 1'b0;
      data_pop     = 1'b0;
      off_sum      = {1'b0, off_q} + (OFF_W+1)'(len_m1_q) + (OFF_W+1)'(1);
      if (end_q) begin
         off_sum = (off_sum + (OFF_W+1)'(BURST_BEATS-1)) &
                   ~((OFF_W+1)'(BURST_BEATS-1));
      end
      unique case (state_q)
         WR_IDLE: begin
            if (!desc_empty) begin
               desc_pop     = 1'b1;
               len_m1_d     = desc_rd[DESC_W-1 -: AXI_BURST_WIDTH];
               beats_left_d = desc_rd[DESC_W-1 -: AXI_BURST_WIDTH];
               end_d        = desc_rd[DESC_BYTES_W];
               bytes_d      = desc_rd[DESC_BYTES_W-1:0];
               state_d      = WR_AW;
            end
         end
         WR_AW: begin
            if (awready) state_d = WR_W;
         end
         WR_W: begin
            if (wready) begin
               data_pop = 1'b1;
               if (beats_left_q == '0) begin
                  // Wrap falls out of the truncation: bursts never cross the ring end.
                  off_d   = off_sum[OFF_W-1:0];
                  state_d = WR_B;
               end else begin
                  beats_left_d = beats_left_q - 1'b1;
               end
            end
         end
         WR_B: begin
            if (bvalid) begin
               if (bresp != AXI_RESP_OKAY) err_d = 1'b1;
               if (end_q) begin
                  done_d       = 1'b1;
                  done_bytes_d = bytes_q;
               end
               state_d = WR_IDLE;
            end
         end
         default: state_d = WR_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pk_word_q    <= '0;
         pk_strb_q    <= '0;
         pk_idx_q     <= '0;
         pk_words_q   <= '0;
         pk_bytes_q   <= '0;
         rdy_en_q     <= 1'b0;
         state_q      <= WR_IDLE;
         len_m1_q     <= '0;
         beats_left_q <= '0;
         end_q        <= 1'b0;
         bytes_q      <= '0;
         off_q        <= '0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
         done_bytes_q <= '0;
      end else begin
         pk_word_q    <= pk_word_d;
         pk_strb_q    <= pk_strb_d;
         pk_idx_q     <= pk_idx_d;
         pk_words_q   <= pk_words_d;
         pk_bytes_q   <= pk_bytes_d;
         rdy_en_q     <= 1'b1;
         state_q      <= state_d;
         len_m1_q     <= len_m1_d;
         beats_left_q <= beats_left_d;
         end_q        <= end_d;
         bytes_q      <= bytes_d;
         off_q        <= off_d;
         err_q        <= err_d;
         done_q       <= done_d;
         done_bytes_q <= done_bytes_d;
      end
   end

   assign awvalid     = (state_q == WR_AW);
   assign awaddr      = BASE_ADDR + AXI_ADDR_WIDTH'(off_q) * AXI_ADDR_WIDTH'(COLS_PER_BEAT);
   assign awlen       = len_m1_q;
   assign awid        = WR_ID;
   assign wvalid      = (state_q == WR_W);
   assign wdata       = wvalid ? data_rd[AXI_DATA_WIDTH-1:0] : '0;
   assign wstrb       = wvalid ? data_rd[DF_W-1 -: BPW] : '0;
   assign wlast       = wvalid && (beats_left_q == '0);
   assign bready      = (state_q == WR_B);
   assign frame_done  = done_q;
   assign frame_bytes = done_bytes_q;
   assign wr_err      = err_q;

endmodule

// File: tb/tb_ddr3_stream_writer.sv
// Self-checking bench: a default-ring instance and a 32-beat-ring instance
// share all inputs and run in lockstep; the second one is checked only on
// its burst addresses.
module tb_ddr3_stream_writer;

   logic         aclk = 1'b0;
   logic         aresetn = 1'b0;
   logic [7:0]   s_data = '0;
   logic         s_valid = 1'b0;
   logic         s_last = 1'b0;
   logic         awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
   logic [1:0]   bresp = 2'd0;
   logic [3:0]   bid = 4'd0;

   logic         s_ready, awvalid, wlast, wvalid, bready, frame_done, wr_err;
   logic [31:0]  awaddr;
   logic [3:0]   awid;
   logic [5:0]   awlen;
   logic [127:0] wdata;
   logic [15:0]  wstrb, frame_bytes;

   logic         s_ready_2, awvalid_2, wlast_2, wvalid_2, bready_2, frame_done_2, wr_err_2;
   logic [31:0]  awaddr_2;
   logic [3:0]   awid_2;
   logic [5:0]   awlen_2;
   logic [127:0] wdata_2;
   logic [15:0]  wstrb_2, frame_bytes_2;

   always #5 aclk = ~aclk;

   ddr3_stream_writer dut (
      .aclk(aclk), .aresetn(aresetn), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .awaddr(awaddr), .awid(awid), .awlen(awlen), .awvalid(awvalid),
      .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
      .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .frame_done(frame_done), .frame_bytes(frame_bytes), .wr_err(wr_err)
   );

   ddr3_stream_writer #(.REGION_BEATS(32)) dut_ring (
      .aclk(aclk), .aresetn(aresetn), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready_2), .awaddr(awaddr_2), .awid(awid_2), .awlen(awlen_2), .awvalid(awvalid_2),
      .awready(awready), .wdata(wdata_2), .wstrb(wstrb_2), .wlast(wlast_2), .wvalid(wvalid_2),
      .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready_2),
      .frame_done(frame_done_2), .frame_bytes(frame_bytes_2), .wr_err(wr_err_2)
   );

   typedef struct packed { logic [31:0] addr; logic [5:0] len; } aw_exp_t;
   typedef struct packed { logic [127:0] data; logic [15:0] strb; logic last; } w_exp_t;
   typedef struct {
      logic        do_rst;
      int          len;
      int          seed;
      logic [31:0] exp_addr0;
      int          exp_naw;
      logic [5:0]  exp_last_len;
      logic [15:0] exp_last_strb;
   } vec_t;

   aw_exp_t     aw_q[$];
   logic [31:0] aw2_q[$];
   w_exp_t      w_q[$];
   logic [15:0] done_q[$];

   int n_tests = 0, n_fail = 0;
   int m_off = 0, m_off2 = 0;
   int b_pending = 0, b_hs_total = 0, err_idx = -1, done_cnt = 0;
   bit aw_stall = 0, w_stall = 0, rand_rdy = 0, gap_en = 0;
   bit aw_hold = 0, w_hold = 0;
   int row_aw = 0;
   logic [31:0] row_first;
   logic [5:0]  row_last_len;
   logic [15:0] row_last_strb, row_done_bytes;
   logic [31:0] ring_addr [3];
   int ring_cnt = 0;
   aw_exp_t mon_aw;
   w_exp_t  mon_w;
   logic [31:0] mon_a2;
   logic [15:0] mon_d;
   vec_t vec [8];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: expected bursts, beats and completion for one frame.
   task automatic model_frame(input int len, input int seed);
      int words, w, n;
      w_exp_t e;
      words = (len + 15) / 16;
      w = 0;
      while (w < words) begin
         n = (words - w > 16) ? 16 : words - w;
         aw_q.push_back({32'(m_off * 8), 6'(n - 1)});
         aw2_q.push_back(32'(m_off2 * 8));
         for (int b = 0; b < n; b++) begin
            e = '0;
            for (int k = 0; k < 16; k++) begin
               if ((w + b) * 16 + k < len) begin
                  e.data[8*k +: 8] = 8'(seed + (w + b) * 16 + k);
                  e.strb[k] = 1'b1;
               end
            end
            e.last = (b == n - 1);
            w_q.push_back(e);
         end
         m_off  = (m_off + n) % 4096;
         m_off2 = (m_off2 + n) % 32;
         w += n;
      end
      m_off  = ((m_off + 15) / 16 * 16) % 4096;
      m_off2 = ((m_off2 + 15) / 16 * 16) % 32;
      done_q.push_back(16'(len));
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      int t;
      @(negedge aclk);
      if (gap_en && $urandom_range(0, 3) == 0) begin
         s_valid = 1'b0;
         @(negedge aclk);
      end
      s_data = d; s_valid = 1'b1; s_last = last;
      #1;
      t = 0;
      while (!s_ready && t < 4000) begin
         @(negedge aclk); #1; t++;
      end
      if (t >= 4000) check("s_ready_timeout", {127'd0, s_ready}, 128'd1);
      @(posedge aclk);
      #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic send_frame(input int len, input int seed);
      model_frame(len, seed);
      for (int i = 0; i < len; i++) send_byte(8'(seed + i), i == len - 1);
   endtask

   task automatic wait_done(input int target);
      int t;
      t = 0;
      while (done_cnt < target && t < 5000) begin
         @(negedge aclk); #1; t++;
      end
      check("frame_done_count", done_cnt, target);
      repeat (3) @(negedge aclk);
      #1;
      check("aw_leftover", aw_q.size(), 0);
      check("w_leftover", w_q.size(), 0);
   endtask

   task automatic do_reset(input bit chk);
      @(negedge aclk);
      aresetn = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      repeat (3) @(negedge aclk);
      aw_q.delete(); aw2_q.delete(); w_q.delete(); done_q.delete();
      m_off = 0; m_off2 = 0;
      aresetn = 1'b1;
      #1;
      if (chk) begin
         check("rst_s_ready_first", s_ready, 0);
         check("rst_awvalid", awvalid, 0);
         check("rst_wvalid", wvalid, 0);
         check("rst_bready", bready, 0);
         check("rst_wlast", wlast, 0);
         check("rst_awaddr", awaddr, 0);
         check("rst_awlen", awlen, 0);
         check("rst_wstrb", wstrb, 0);
         check("rst_frame_done", frame_done, 0);
         check("rst_frame_bytes", frame_bytes, 0);
         check("rst_wr_err", wr_err, 0);
         check("rst_awid", awid, 0);
      end
      @(negedge aclk); #1;
      if (chk) check("rst_s_ready_after", s_ready, 1);
   endtask

   initial begin
      int tgt;
      bit saw_low;
      int t;

      //            rst  len   seed   addr0   naw last_len last_strb
      vec[0] = '{1'b1,  16, 'h00, 32'd0,   1, 6'd0,  16'hFFFF};
      vec[1] = '{1'b1, 300, 'h10, 32'd0,   2, 6'd2,  16'h0FFF};
      vec[2] = '{1'b0,  10, 'h55, 32'd256, 1, 6'd0,  16'h03FF};
      vec[3] = '{1'b1, 256, 'hA0, 32'd0,   1, 6'd15, 16'hFFFF};
      vec[4] = '{1'b0,   1, 'h7E, 32'd128, 1, 6'd0,  16'h0001};
      vec[5] = '{1'b0,  17, 'h20, 32'd256, 1, 6'd1,  16'h0001};
      vec[6] = '{1'b0, 512, 'h01, 32'd384, 2, 6'd15, 16'hFFFF};
      vec[7] = '{1'b0,  33, 'hC3, 32'd640, 1, 6'd2,  16'h0001};

      fork
         // AXI slave: drives ready/response inputs on the falling edge.
         forever begin
            @(negedge aclk);
            awready = !aw_stall && (!rand_rdy || $urandom_range(0, 1) == 1);
            wready  = !w_stall && (!rand_rdy || $urandom_range(0, 2) != 0);
            bvalid  = aresetn && (b_pending > 0);
            bresp   = (b_hs_total == err_idx) ? 2'd2 : 2'd0;
         end
         // Monitor / scoreboard: samples just after the falling edge.
         forever begin
            @(negedge aclk); #1;
            if (!aresetn) begin
               b_pending = 0; aw_hold = 0; w_hold = 0;
            end else begin
               if (aw_hold) check("awvalid_held", awvalid, 1);
               if (w_hold) check("wvalid_held", wvalid, 1);
               aw_hold = awvalid && !awready;
               w_hold  = wvalid && !wready;
               if (awvalid && awready) begin
                  check("aw_expected", aw_q.size() > 0, 1);
                  if (aw_q.size() > 0) begin
                     mon_aw = aw_q.pop_front();
                     check("awaddr", awaddr, mon_aw.addr);
                     check("awlen", awlen, mon_aw.len);
                  end
                  if (row_aw == 0) row_first = awaddr;
                  row_last_len = awlen;
                  row_aw++;
               end
               if (awvalid_2 && awready) begin
                  check("aw_ring_expected", aw2_q.size() > 0, 1);
                  if (aw2_q.size() > 0) begin
                     mon_a2 = aw2_q.pop_front();
                     check("awaddr_ring", awaddr_2, mon_a2);
                  end
                  if (ring_cnt < 3) ring_addr[ring_cnt] = awaddr_2;
                  ring_cnt++;
               end
               if (wvalid && wready) begin
                  check("w_expected", w_q.size() > 0, 1);
                  if (w_q.size() > 0) begin
                     mon_w = w_q.pop_front();
                     check("wdata", wdata, mon_w.data);
                     check("wstrb", wstrb, mon_w.strb);
                     check("wlast", wlast, mon_w.last);
                  end
                  row_last_strb = wstrb;
                  if (wlast) b_pending++;
               end
               if (bvalid && bready) begin
                  b_pending--;
                  b_hs_total++;
               end
               if (frame_done) begin
                  check("done_expected", done_q.size() > 0, 1);
                  if (done_q.size() > 0) begin
                     mon_d = done_q.pop_front();
                     check("frame_bytes", frame_bytes, mon_d);
                  end
                  row_done_bytes = frame_bytes;
                  done_cnt++;
               end
            end
         end
         begin
            #400000;
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog");
         end
      join_none

      // Table-driven frames.
      for (int r = 0; r < 8; r++) begin
         if (vec[r].do_rst) do_reset(r == 0);
         row_aw = 0; row_first = '1; row_last_len = '0; row_last_strb = '0;
         tgt = done_cnt + 1;
         send_frame(vec[r].len, vec[r].seed);
         wait_done(tgt);
         check("row_addr0", row_first, vec[r].exp_addr0);
         check("row_bursts", row_aw, vec[r].exp_naw);
         check("row_last_len", row_last_len, vec[r].exp_last_len);
         check("row_last_strb", row_last_strb, vec[r].exp_last_strb);
         check("row_done_bytes", row_done_bytes, 16'(vec[r].len));
      end

      // Back-pressure: both AXI channels stalled while 1 kB arrives.
      do_reset(0);
      aw_stall = 1; w_stall = 1;
      tgt = done_cnt + 1;
      fork
         send_frame(1024, 'h33);
         begin
            saw_low = 0; t = 0;
            while (!saw_low && t < 3000) begin
               @(negedge aclk); #1;
               if (!s_ready) saw_low = 1;
               t++;
            end
            check("s_ready_drops", saw_low, 1);
            repeat (50) @(negedge aclk);
            aw_stall = 0; w_stall = 0; rand_rdy = 1;
         end
      join
      wait_done(tgt);
      rand_rdy = 0;

      // Error response on the first burst; stream continues, error sticks.
      do_reset(0);
      check("err_clear_after_reset", wr_err, 0);
      err_idx = b_hs_total;
      tgt = done_cnt + 1;
      send_frame(300, 'h44);
      wait_done(tgt);
      check("wr_err_set", wr_err, 1);
      err_idx = -1;
      tgt = done_cnt + 1;
      send_frame(16, 'h90);
      wait_done(tgt);
      check("wr_err_sticky", wr_err, 1);

      // 32-beat ring: third 256-byte frame wraps to the start.
      do_reset(0);
      ring_cnt = 0; gap_en = 1;
      for (int f = 0; f < 3; f++) begin
         tgt = done_cnt + 1;
         send_frame(256, f * 7);
         wait_done(tgt);
      end
      gap_en = 0;
      check("ring_count", ring_cnt, 3);
      check("ring_addr0", ring_addr[0], 32'd0);
      check("ring_addr1", ring_addr[1], 32'd128);
      check("ring_addr2", ring_addr[2], 32'd0);

      // Reset while a burst is pending on AW with a partial frame buffered.
      aw_stall = 1;
      for (int i = 0; i < 300; i++) send_byte(8'(i), 1'b0);
      repeat (3) @(negedge aclk);
      #1;
      check("mid_awvalid", awvalid, 1);
      do_reset(1);
      aw_stall = 0;
      row_aw = 0; row_first = '1;
      tgt = done_cnt + 1;
      send_frame(16, 'h80);
      wait_done(tgt);
      check("post_reset_addr0", row_first, 32'd0);
      check("post_reset_bytes", row_done_bytes, 16'd16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr3_stream_writer.md
# ddr3_stream_writer

Packs an incoming 8-bit frame stream (UDP payload side) into 128-bit words and writes it to DDR3 as AXI write bursts. It sits directly upstream of `axi_ddr3`: it is the master driving its AW/W/B channels. Frames land contiguously in a ring region, each frame starting on a burst boundary. A completion pulse reports each frame's byte count once its last burst is acknowledged.

## Interface
- `AXI_ADDR_WIDTH`, default 32: AW address width.
- `AXI_ID_WIDTH`, default 4: AWID/BID width.
- `AXI_BURST_WIDTH`, default 6: AWLEN width.
- `AXI_DATA_WIDTH`, default 128: word width; `AXI_DATA_WIDTH/8` = 16 bytes per word.
- `BURST_BEATS`, default 16: maximum beats per burst, power of 2, at most 2^AXI_BURST_WIDTH.
- `BASE_ADDR`, default 0: ring start address, in 16-bit DDR column units.
- `REGION_BEATS`, default 4096: ring size in beats, a power-of-2 multiple of `BURST_BEATS`.
- `WR_ID`, default 0: constant AWID.

Ports:
- `aclk` in 1: single clock.
- `aresetn` in 1: asynchronous, active-low reset. This is decided.
- `s_data` in 8: payload byte.
- `s_valid` in 1: byte valid.
- `s_last` in 1: last byte of the frame.
- `s_ready` out 1: byte accepted when `s_valid & s_ready`.
- `awaddr` out AXI_ADDR_WIDTH: burst start address.
- `awid` out AXI_ID_WIDTH: always `WR_ID`.
- `awlen` out AXI_BURST_WIDTH: beats−1.
- `awvalid` out 1; `awready` in 1.
- `wdata` out 128; `wstrb` out 16.
- `wlast` out 1: last-beat marker for AXI compliance. Downstream derives its own last beat from `awlen`.
- `wvalid` out 1; `wready` in 1.
- `bid` in AXI_ID_WIDTH, ignored; `bresp` in 2; `bvalid` in 1; `bready` out 1.
- `frame_done` out 1: one-cycle pulse.
- `frame_bytes` out 16: byte count, valid while `frame_done` is high.
- `wr_err` out 1: sticky; set when any `bresp` ≠ OKAY.

## Operation
**Packer**
- Bytes are placed little-endian: byte k of a word goes to bits `[8k+7:8k]`.
- A word is pushed to the data FIFO on the 16th byte, or on the `s_last` byte.
- A partial final word has `wstrb` = ones only for bytes written; unused bytes are 0.
- The packer counts words per frame. After every `BURST_BEATS` words, and at frame end, it pushes a descriptor `{len−1, frame_end, frame_bytes}` to the descriptor FIFO.
- A frame end that coincides with a full burst produces exactly one descriptor, with `frame_end=1`.
- `s_ready` = data FIFO has ≥1 free entry AND descriptor FIFO has ≥1 free entry.
- `frame_bytes` wraps modulo 2^16.

**Writer FSM**
- IDLE: when the descriptor FIFO is non-empty, pop a descriptor, latch it, go to AW.
- AW: `awvalid=1`, `awaddr = BASE_ADDR + 8*offset`, `awlen = len−1`. On `awready`, go to W.
- W: `wvalid=1` and words are popped from the data FIFO on `wvalid & wready`. `wlast` is high on beat `len−1`. After the last beat, go to B.
- B: `bready=1`. On `bvalid`, set `wr_err` if `bresp≠0`, and pulse `frame_done` if `frame_end`. Then go to IDLE.

**Addressing**
- `offset` is a beat counter modulo `REGION_BEATS`. It advances by `len` after each burst.
- At `frame_end`, `offset` is rounded up to the next `BURST_BEATS` multiple, wrapping to 0 at `REGION_BEATS`. Bursts therefore never cross the ring end.

**Invariant**
- A descriptor is only pushed after its words are in the data FIFO, so W never underflows. The writer must not wait on FIFO count in W.

## Timing
- Reset values: `s_ready=0` for the first cycle after reset release, then per the FIFO rule. `awvalid=wvalid=bready=wlast=0`; `awaddr=BASE_ADDR`; `awlen=0`; `wstrb=0`; `frame_done=0`; `frame_bytes=0`; `wr_err=0`; `offset=0`; FSM in IDLE.
- `awvalid`, `awaddr` and `awlen` are held stable until the handshake. The same holds for `wvalid` and `wdata`.
- Word push: one cycle after the completing byte. Descriptor push: same cycle as the word push.
- IDLE→AW: one cycle after the descriptor FIFO becomes non-empty.
- W streams one beat per cycle while `wready` is high.
- `frame_done` asserts the cycle after the `bvalid` is accepted.
- A byte push and a word pop in the same cycle are both honoured.
- A reset mid-burst discards all FIFOs, the partial word and the FSM state.

## Structure
- Shared package (`ddr3_axi_pkg`): AXI response localparams (OKAY=0…DECERR=3), writer FSM state encoding, and the descriptor field widths.
- One sub-module, `sfifo` (width/depth parameters, `fifo_full`/`fifo_empty`), instantiated twice:
  - data FIFO: width 144 (data + strb), depth 32;
  - descriptor FIFO: width AXI_BURST_WIDTH+1+16, depth 4.

## Test plan
- **One 16-byte frame**, bytes 0x00..0x0F → one burst: `awaddr=BASE_ADDR`, `awlen=0`, `wdata=0x0F0E…0100`, `wstrb=0xFFFF`, `wlast=1`; `frame_done` with `frame_bytes=16`.
- **Frame of 300 bytes** → bursts of 16 and 3 beats, `awaddr` 0 then 128. The final `wstrb=0x0FFF`; `frame_bytes=300`. The next frame starts at `awaddr=256`.
- **Frame of exactly 256 bytes** → one 16-beat burst with a single `frame_done`. The next frame starts at `awaddr=128`.
- **`REGION_BEATS=32`**, three 256-byte frames → `awaddr` 0, 128, then 0 (wrap).
- **`awready` and `wready` held low for 50 cycles** while a 1 kB stream arrives → `s_ready` drops when the FIFOs fill. No byte is lost or duplicated, checked against a reference memory model.
- **`bresp=2`** on the first burst → `wr_err=1` and stays set; the stream continues and `frame_done` still fires.
